// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard decode types and constants: FSM states, prefix codes, shift codes.
package kbd_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BREAK     = 2'd1,
      EXT       = 2'd2,
      EXT_BREAK = 2'd3
   } kbd_state_t;

   localparam logic [7:0] BREAK_CODE  = 8'hF0;
   localparam logic [7:0] EXT_CODE    = 8'hE0;
   localparam logic [7:0] LSHIFT_CODE = 8'h12;
   localparam logic [7:0] RSHIFT_CODE = 8'h59;

   function automatic logic is_shift(input logic [7:0] code);
      return (code == LSHIFT_CODE) || (code == RSHIFT_CODE);
   endfunction

   function automatic logic [7:0] to_upper(input logic [7:0] ascii);
      if (ascii >= 8'h61 && ascii <= 8'h7A)
         return ascii - 8'h20;
      return ascii;
   endfunction

endpackage

// File: rtl/kbd_scan_lut.sv
// Set-2 make code to lower-case ASCII for digits and letters; combinational, no backpressure.
// Anything not listed maps to 0x00, which the controller treats as "ignore".
module kbd_scan_lut (
   input  logic [7:0] scan,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = 8'h00;
      case (scan)
         8'h45: ascii = 8'h30;
         8'h16: ascii = 8'h31;
         8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;
         8'h25: ascii = 8'h34;
         8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;
         8'h3D: ascii = 8'h37;
         8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         8'h1C: ascii = 8'h61;
         8'h32: ascii = 8'h62;
         8'h21: ascii = 8'h63;
         8'h23: ascii = 8'h64;
         8'h24: ascii = 8'h65;
         8'h2B: ascii = 8'h66;
         8'h34: ascii = 8'h67;
         8'h33: ascii = 8'h68;
         8'h43: ascii = 8'h69;
         8'h3B: ascii = 8'h6A;
         8'h42: ascii = 8'h6B;
         8'h4B: ascii = 8'h6C;
         8'h3A: ascii = 8'h6D;
         8'h31: ascii = 8'h6E;
         8'h44: ascii = 8'h6F;
         8'h4D: ascii = 8'h70;
         8'h15: ascii = 8'h71;
         8'h2D: ascii = 8'h72;
         8'h1B: ascii = 8'h73;
         8'h2C: ascii = 8'h74;
         8'h3C: ascii = 8'h75;
         8'h2A: ascii = 8'h76;
         8'h1D: ascii = 8'h77;
         8'h22: ascii = 8'h78;
         8'h35: ascii = 8'h79;
         8'h1A: ascii = 8'h7A;
         default: ascii = 8'h00;
      endcase
   end

endmodule

// File: rtl/kbd_ctrl.sv
// PS/2 scan-byte decoder: key outputs update 1 cycle after the handshake; scan_ready drops only during clr.
// Optional KBD_SHIFT_EN tracks left/right shift and upper-cases letters.
module kbd_ctrl
   import kbd_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       scan_data,
   input  logic             scan_valid,
   output logic             scan_ready,
   input  logic             clr,
   output logic [7:0]       key_scan,
   output logic [7:0]       key_ascii,
   output logic             key_held,
   output logic             key_evt,
   output logic [CNT_W-1:0] press_cnt
);

   kbd_state_t state, state_nxt;
   logic       accept;
   logic [7:0] lut_ascii;
   logic [7:0] load_ascii;
   logic       idle_acc, brk_acc, press_new, release_hit;

   assign scan_ready = ~clr;
   assign accept     = scan_valid & scan_ready;

   kbd_scan_lut u_lut (
      .scan  (scan_data),
      .ascii (lut_ascii)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = IDLE;
      end else if (accept) begin
         case (state)
            IDLE: begin
               if (scan_data == BREAK_CODE)
                  state_nxt = BREAK;
               else if (scan_data == EXT_CODE)
                  state_nxt = EXT;
            end
            EXT: begin
               if (scan_data == BREAK_CODE)
                  state_nxt = EXT_BREAK;
               else
                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // A repeat of the held key is typematic auto-repeat, not a new press.
   always_comb begin
      idle_acc    = accept && (state == IDLE);
      brk_acc     = accept && (state == BREAK);
      press_new   = idle_acc && (scan_data != BREAK_CODE) && (scan_data != EXT_CODE)
                    && (lut_ascii != 8'h00)
                    && !(key_held && (scan_data == key_scan));
      release_hit = brk_acc && (scan_data == key_scan);
   end

`ifdef KBD_SHIFT_EN
   logic shift_held;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         shift_held <= 1'b0;
      else if (clr)
         shift_held <= 1'b0;
      else if (idle_acc && is_shift(scan_data))
         shift_held <= 1'b1;
      else if (brk_acc && is_shift(scan_data))
         shift_held <= 1'b0;
   end

   assign load_ascii = shift_held ? to_upper(lut_ascii) : lut_ascii;
`else
   assign load_ascii = lut_ascii;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_scan  <= 8'h00;
         key_ascii <= 8'h00;
         key_held  <= 1'b0;
         key_evt   <= 1'b0;
         press_cnt <= '0;
      end else begin
         key_evt <= press_new;
         if (press_new) begin
            key_scan  <= scan_data;
            key_ascii <= load_ascii;
         end
         if (clr)
            press_cnt <= '0;
         else if (press_new)
            press_cnt <= press_cnt + CNT_W'(1);
         if (clr)
            key_held <= 1'b0;
         else if (press_new)
            key_held <= 1'b1;
         else if (release_hit)
            key_held <= 1'b0;
      end
   end

endmodule

// File: tb/tb_kbd_ctrl.sv
// Directed stimulus for kbd_ctrl; a negedge monitor pops expected key events from a scoreboard.
module tb_kbd_ctrl;

   typedef struct packed {
      logic [7:0] scan;
      logic [7:0] ascii;
      logic       held;
      logic [7:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] scan_data = 8'h00;
   logic       scan_valid = 1'b0;
   logic       scan_ready;
   logic       clr = 1'b0;
   logic [7:0] key_scan;
   logic [7:0] key_ascii;
   logic       key_held;
   logic       key_evt;
   logic [7:0] press_cnt;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;

   kbd_ctrl #(.CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_data  (scan_data),
      .scan_valid (scan_valid),
      .scan_ready (scan_ready),
      .clr        (clr),
      .key_scan   (key_scan),
      .key_ascii  (key_ascii),
      .key_held   (key_held),
      .key_evt    (key_evt),
      .press_cnt  (press_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && key_evt) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL evt_unexpected: got scan=%h ascii=%h held=%b cnt=%0d, expected no event",
                     key_scan, key_ascii, key_held, press_cnt);
         end else begin
            mon_e = sb.pop_front();
            if ({key_scan, key_ascii, key_held, press_cnt} !== mon_e) begin
               errors++;
               $display("FAIL evt_fields: got scan=%h ascii=%h held=%b cnt=%0d, expected scan=%h ascii=%h held=%b cnt=%0d",
                        key_scan, key_ascii, key_held, press_cnt,
                        mon_e.scan, mon_e.ascii, mon_e.held, mon_e.cnt);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic send(input logic [7:0] b);
      scan_data  = b;
      scan_valid = 1'b1;
      @(posedge clk);
      #1;
      scan_valid = 1'b0;
   endtask

   task automatic press(input logic [7:0] b, input logic [7:0] a, input logic [7:0] c);
      exp_t x;
      x.scan  = b;
      x.ascii = a;
      x.held  = 1'b1;
      x.cnt   = c;
      sb.push_back(x);
      send(b);
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_scan"},  32'(key_scan),  32'h00);
      chk({tag, "_ascii"}, 32'(key_ascii), 32'h00);
      chk({tag, "_held"},  32'(key_held),  32'h0);
      chk({tag, "_evt"},   32'(key_evt),   32'h0);
      chk({tag, "_cnt"},   32'(press_cnt), 32'h0);
   endtask

   initial begin
      #2;
      chk_reset_vals("rst");
      chk("rst_ready", 32'(scan_ready), 32'h1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_cycles(1);

      // First press and typematic repeats.
      press(8'h1C, 8'h61, 8'd1);
      send(8'h1C);
      send(8'h1C);
      idle_cycles(1);
      chk("typematic_cnt", 32'(press_cnt), 32'd1);
      send(8'hF0);
      send(8'h1C);
      chk("release_held", 32'(key_held), 32'h0);
      chk("release_ascii", 32'(key_ascii), 32'h61);
      chk("release_scan", 32'(key_scan), 32'h1C);

      // Same key again after release counts; extended sequences are ignored.
      press(8'h1C, 8'h61, 8'd2);
      send(8'hE0);
      send(8'h75);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      chk("ext_scan", 32'(key_scan), 32'h1C);
      chk("ext_held", 32'(key_held), 32'h1);
      chk("ext_cnt", 32'(press_cnt), 32'd2);
      press(8'h32, 8'h62, 8'd3);
      idle_cycles(1);
      chk("ext_back_idle_cnt", 32'(press_cnt), 32'd3);

      // Prefix byte as break target: no match, back to IDLE (not EXT).
      send(8'hF0);
      send(8'hE0);
      press(8'h1C, 8'h61, 8'd4);
      send(8'h76);
      send(8'h00);
`ifndef KBD_SHIFT_EN
      send(8'h12);
      send(8'h59);
`endif
      idle_cycles(1);
      chk("unmapped_cnt", 32'(press_cnt), 32'd4);

      // clr beats a simultaneous byte.
      clr        = 1'b1;
      scan_data  = 8'h32;
      scan_valid = 1'b1;
      #1;
      chk("clr_ready", 32'(scan_ready), 32'h0);
      @(posedge clk);
      #1;
      clr        = 1'b0;
      scan_valid = 1'b0;
      chk("clr_cnt", 32'(press_cnt), 32'd0);
      chk("clr_held", 32'(key_held), 32'h0);
      chk("clr_scan_kept", 32'(key_scan), 32'h1C);

      // 255 distinct presses then one more wraps the counter.
      for (int i = 0; i < 255; i++) begin
         if (i % 2 == 0)
            press(8'h32, 8'h62, 8'(i + 1));
         else
            press(8'h1C, 8'h61, 8'(i + 1));
      end
      press(8'h16, 8'h31, 8'd0);
      chk("wrap_cnt", 32'(press_cnt), 32'd0);
      chk("wrap_ascii", 32'(key_ascii), 32'h31);

      // Reset with a pending break discards it.
      send(8'hF0);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      press(8'h1C, 8'h61, 8'd1);
      chk("post_rst_held", 32'(key_held), 32'h1);

`ifdef KBD_SHIFT_EN
      send(8'hF0);
      send(8'h1C);
      send(8'h12);
      press(8'h1C, 8'h41, 8'd2);
      send(8'hF0);
      send(8'h12);
      chk("shift_rel_held", 32'(key_held), 32'h1);
      chk("shift_rel_cnt", 32'(press_cnt), 32'd2);
      press(8'h32, 8'h62, 8'd3);
      send(8'h59);
      press(8'h16, 8'h31, 8'd4);
`endif

      idle_cycles(3);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/kbd_ctrl.md
KBD_CTRL -- requirements
Module: kbd_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of the key-press counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have port scan_data, input, 8 bits: PS/2 scan byte from the receiver.
REQ-005 SHALL have port scan_valid, input, 1 bit: scan_data is valid this cycle.
REQ-006 SHALL have port scan_ready, output, 1 bit: the block accepts a byte when scan_valid & scan_ready.
REQ-007 SHALL have port clr, input, 1 bit: synchronous soft clear.
REQ-008 SHALL have port key_scan, output, 8 bits: make code of the last accepted key.
REQ-009 SHALL have port key_ascii, output, 8 bits: ASCII of the last accepted key.
REQ-010 SHALL have port key_held, output, 1 bit: the last accepted key is still pressed.
REQ-011 SHALL have port key_evt, output, 1 bit: one-cycle pulse per new key press.
REQ-012 SHALL have port press_cnt, output, CNT_W bits: count of new key presses.

Function
REQ-013 SHALL implement FSM states IDLE, BREAK (after 0xF0), EXT (after 0xE0) and EXT_BREAK (after 0xE0 0xF0).
REQ-014 SHALL make these transitions on accepted bytes: IDLE on 0xF0 -> BREAK; IDLE on 0xE0 -> EXT; EXT on 0xF0 -> EXT_BREAK; any other byte in EXT or EXT_BREAK -> IDLE, with no output change (extended keys ignored).
REQ-015 SHALL treat a byte in IDLE as a make code; codes mapping to ASCII 0x00 SHALL be ignored.
REQ-016 SHALL, for a mapped make code equal to key_scan while key_held=1 (typematic repeat), leave all outputs unchanged, with no key_evt and no count.
REQ-017 SHALL, for any other mapped make code, load key_scan and key_ascii, set key_held=1, pulse key_evt and increment press_cnt, all at the acceptance edge (latency 1 cycle: visible the cycle after the handshake).
REQ-018 SHALL have press_cnt wrap from 2^CNT_W-1 to 0 silently.
REQ-019 SHALL, for a byte in BREAK, clear key_held if the byte equals key_scan, otherwise change nothing, then return to IDLE; key_ascii and key_scan SHALL retain their values.
REQ-020 SHALL drive scan_ready=1 except in any cycle where clr=1.
REQ-021 SHALL, when clr=1, return the FSM to IDLE, zero press_cnt and key_held, hold key_evt=0 and accept no byte (clr wins over a simultaneous scan_valid).
REQ-022 SHALL treat a 0xF0 or 0xE0 received in BREAK as the break target (no match) and return to IDLE.

Reset
REQ-023 SHALL, on rst_n=0, immediately set FSM=IDLE, key_scan=0x00, key_ascii=0x00, key_held=0, key_evt=0 and press_cnt=0.
REQ-024 SHALL discard any partially received sequence (e.g. pending 0xF0) on reset mid-operation.

Configuration
REQ-025 SHALL, with macro KBD_SHIFT_EN defined, track shift_held from make/break of 0x12 and 0x59, with shift bytes neither counted nor changing key_* outputs.
REQ-026 SHALL, with KBD_SHIFT_EN defined and shift_held=1, output key_ascii in upper case (0x61-0x7A minus 0x20) for letters and unchanged for digits.
REQ-027 SHALL, with KBD_SHIFT_EN defined, clear shift_held on reset and on clr.
REQ-028 SHALL, without KBD_SHIFT_EN, treat 0x12 and 0x59 as unmapped and ignore them, with output always lower case.

Structure
REQ-029 SHALL define the FSM state enum, BREAK_CODE=0xF0, EXT_CODE=0xE0 and the shift codes in shared package kbd_pkg.
REQ-030 SHALL place the combinational scan-to-ASCII lookup (digits 0-9 and a-z, default 0x00) in sub-module kbd_scan_lut.

Verification
REQ-031 SHALL cover: 0x1C accepted -> next cycle key_ascii=0x61, key_scan=0x1C, key_held=1, key_evt pulse, press_cnt=1.
REQ-032 SHALL cover: 0x1C 0x1C 0x1C -> press_cnt=1 with a single key_evt; then 0xF0 0x1C -> key_held=0 and key_ascii still 0x61.
REQ-033 SHALL cover: 0xE0 0x75 and 0xE0 0xF0 0x75 -> no output change and FSM back in IDLE.
REQ-034 SHALL cover: 255 distinct presses then 0x16 (CNT_W=8) -> press_cnt wraps to 0 and key_ascii=0x31.
REQ-035 SHALL cover: clr together with scan_valid and 0x32 -> scan_ready=0, byte dropped, press_cnt=0; rst_n low after 0xF0 -> the next 0x1C is treated as a make.
REQ-036 SHALL cover, with KBD_SHIFT_EN: 0x12 then 0x1C -> key_ascii=0x41; 0xF0 0x12 then 0x32 -> key_ascii=0x62.
